m_divider_seq: RTL and testbench
================================

# m_divider_seq

Parametrised sequential divide unit for the M-extension datapath: it executes DIV, DIVU, REM and REMU using restoring shift-subtract division, with a built-in controller and a start/busy/done handshake. It generalises the fixed 32-bit remainder/divisor/quotient register set to any XLEN. It also retires a configurable number of quotient bits per cycle, and resolves the RISC-V divide-by-zero and signed-overflow cases in hardware. It sits beside the multiplier in the M unit and is driven directly by the decoded instruction.

## Interface
- XLEN, 32, operand/result width; even, ≥ 4
- UNROLL, 1, quotient bits per cycle; 1, 2 or 4, must divide XLEN
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- rs1  in  XLEN  dividend
- rs2  in  XLEN  divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  quotient or remainder, held until next done

## Operation
- Internal registers:
  - R (XLEN): running remainder.
  - D (2·XLEN−1): divisor, shifted right.
  - Z (XLEN): quotient.
  - cnt: ceil(log2(XLEN/UNROLL+1)) bits.
  - Latched op, neg_q, neg_r.
- States:
  - IDLE: if start, capture operands and go to CALC; special cases go to FIN instead.
  - CALC: runs XLEN/UNROLL cycles, then goes to FIN.
  - FIN: writes result, pulses done, returns to IDLE.
- Capture on start in IDLE:
  - signed = ~op[0]
  - R = (signed & rs1[XLEN−1]) ? −rs1 : rs1
  - D = |rs2| << (XLEN−1), with the absolute value taken only when signed
  - Z = 0
  - neg_q = signed & (rs1[MSB] ^ rs2[MSB])
  - neg_r = signed & rs1[MSB]
- One iteration:
  - diff = {0, R} − D, computed in 2·XLEN bits.
  - If diff ≥ 0: R ← diff[XLEN−1:0] and Z ← (Z<<1)|1.
  - Otherwise: R holds and Z ← Z<<1.
  - D ← D>>1.
  - UNROLL iterations are chained combinationally per cycle.
- Sign fixup in FIN:
  - Quotient = neg_q ? −Z : Z.
  - Remainder = neg_r ? −R : R.
  - op[1] selects the remainder.
- Special cases, detected at capture; these go straight to FIN with preset values:
  - rs2 == 0: quotient = all ones; remainder = rs1.
  - Signed op with rs1 == 1<<(XLEN−1) and rs2 == all ones: quotient = rs1; remainder = 0.
- Arithmetic is modulo 2^XLEN; the negation of the most negative value wraps to itself (unsigned magnitude is correct).

## Timing
- Reset, asynchronous: state IDLE; busy = 0, done = 0, result = 0, R/D/Z/cnt = 0. Reset asserted mid-operation aborts with no done.
- Start is sampled at edge E0; busy is registered high after E0.
- Normal path:
  - CALC occupies edges E1..E(XLEN/UNROLL).
  - FIN is written at E(XLEN/UNROLL+1): done = 1 and result valid for that one cycle, busy = 0 in the same cycle.
  - Latency from start to done is XLEN/UNROLL+1 edges (33 for the defaults).
- Special-case path: FIN at E1, so done follows 1 edge after start.
- start while busy: ignored; operands may change freely.
- start during the done cycle: state is IDLE, so it is accepted; back-to-back operations have no bubble.
- done is never asserted for two consecutive cycles.
- result is stable from done until the next done; it is not cleared when an operation starts.

## Test plan
- DIVU 789/7: done exactly 33 cycles after start, result = 112. REMU with the same operands gives 5.
- DIV −7890/456 gives 0xFFFFFFEF (−17). REM with the same operands gives 0xFFFFFF76 (−138). REM 7890/−456 gives 138.
- Divide by zero: DIVU 123/0 gives 0xFFFFFFFF, with done 1 cycle after start. REM −5/0 gives 0xFFFFFFFB.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 in 1 cycle. REM with the same operands gives 0.
- Handshake:
  - start held high through a DIVU 100/3 run produces exactly one done (result 33) per accepted operation, and a second operation begins on the done cycle.
  - resetn pulled low at cycle 10 of a run forces busy = 0, done = 0 and result = 0 immediately; no done follows.
- UNROLL = 4, XLEN = 32: DIVU 0xFFFFFFFF/3 gives 0x55555555, with done 9 cycles after start. UNROLL = 2, XLEN = 16: DIV 0x8000/0x0003 gives 0xD556.

Source files
------------

// File: rtl/m_divider_seq.sv
// m_divider_seq: sequential restoring divider for DIV/DIVU/REM/REMU with start/busy/done handshake
//   clk, resetn (async active-low), start, op (funct3[1:0]), rs1 dividend, rs2 divisor
//   busy (op in progress), done (one-cycle result pulse), result (held until next done)
module m_divider_seq #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int DW    = 2 * XLEN - 1;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state;
  logic [XLEN-1:0] r, z, r_nx, z_nx, abs1, abs2;
  logic [DW-1:0] d, d_nx;
  logic [CW-1:0] cnt;
  logic rem, neg_q, neg_r, sgn, div0, ovf, spec, ge;
  assign sgn  = ~op[0];
  assign abs1 = (sgn & rs1[XLEN-1]) ? -rs1 : rs1;
  assign abs2 = (sgn & rs2[XLEN-1]) ? -rs2 : rs2;
  assign div0 = rs2 == '0;
  assign ovf  = sgn & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2);
  assign spec = div0 | ovf;
  // R >= D compared at full divisor width is the non-negative test of {0,R}-D
  always_comb begin
    r_nx = r;
    z_nx = z;
    d_nx = d;
    ge   = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      ge   = {{(XLEN-1){1'b0}}, r_nx} >= d_nx;
      r_nx = ge ? r_nx - d_nx[XLEN-1:0] : r_nx;
      z_nx = {z_nx[XLEN-2:0], ge};
      d_nx = d_nx >> 1;
    end
  end
  // special cases preload Z/R with the final answers and clear the sign flags
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      r      <= '0;
      d      <= '0;
      z      <= '0;
      cnt    <= '0;
      rem    <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          rem   <= op[1];
          cnt   <= CW'(STEPS);
          d     <= {abs2, {(XLEN-1){1'b0}}};
          neg_q <= ~spec & sgn & (rs1[XLEN-1] ^ rs2[XLEN-1]);
          neg_r <= ~spec & sgn & rs1[XLEN-1];
          r     <= div0 ? rs1 : ovf ? '0 : abs1;
          z     <= div0 ? '1 : ovf ? rs1 : '0;
          state <= spec ? FIN : CALC;
        end
        CALC: begin
          r     <= r_nx;
          z     <= z_nx;
          d     <= d_nx;
          cnt   <= cnt - CW'(1);
          state <= (cnt == CW'(1)) ? FIN : CALC;
        end
        FIN: begin
          result <= rem ? (neg_r ? -r : r) : (neg_q ? -z : z);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_m_divider_seq.sv
// tb_m_divider_seq: self-checking bench for m_divider_seq in three configurations
module tb_m_divider_seq;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, start16 = 1'b0;
  logic [1:0] op = 2'b0, op16 = 2'b0;
  logic [31:0] rs1 = '0, rs2 = '0, result, result4;
  logic [15:0] a16 = '0, b16 = '0, result16;
  logic busy, done, busy4, done4, busy16, done16;
  int tests = 0, fails = 0;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  always #5 clk = ~clk;
  m_divider_seq #(.XLEN(32), .UNROLL(1)) dut (.clk(clk), .resetn(resetn), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result));
  m_divider_seq #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .resetn(resetn), .start(start), .op(op),
    .rs1(rs1), .rs2(rs2), .busy(busy4), .done(done4), .result(result4));
  m_divider_seq #(.XLEN(16), .UNROLL(2)) dut16 (.clk(clk), .resetn(resetn), .start(start16), .op(op16),
    .rs1(a16), .rs2(b16), .busy(busy16), .done(done16), .result(result16));
  function automatic logic [31:0] model(int w, logic [1:0] o, logic [31:0] a, logic [31:0] b);
    longint m  = (longint'(1) << w) - 1;
    longint ua = longint'(a) & m;
    longint ub = longint'(b) & m;
    longint sa = ua[w-1] ? ua - (m + 1) : ua;
    longint sb = ub[w-1] ? ub - (m + 1) : ub;
    longint q, rr;
    if (ub == 0) begin
      q  = m;
      rr = ua;
    end else if (!o[0]) begin
      q  = sa / sb;
      rr = sa % sb;
    end else begin
      q  = ua / ub;
      rr = ua % ub;
    end
    return 32'(o[1] ? (rr & m) : (q & m));
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(string name, logic [1:0] o, logic [31:0] a, logic [31:0] b, logic [31:0] exp, int lat);
    int n1 = -1, n4 = -1, c1 = 0, c4 = 0;
    int lat4 = (lat == 1) ? 1 : 9;
    start = 1'b1;
    op = o;
    rs1 = a;
    rs2 = b;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk($sformatf("%s busy", name), 32'(busy), 32'd1);
        start = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        op = 2'($urandom);
      end
      if (done) begin
        c1++;
        if (n1 < 0) begin
          n1 = k - 1;
          chk($sformatf("%s result", name), result, exp);
        end
      end
      if (done4) begin
        c4++;
        if (n4 < 0) begin
          n4 = k - 1;
          chk($sformatf("%s result_u4", name), result4, exp);
        end
      end
    end
    chk($sformatf("%s latency", name), 32'(n1), 32'(lat));
    chk($sformatf("%s latency_u4", name), 32'(n4), 32'(lat4));
    chk($sformatf("%s done_count", name), 32'(c1), 32'd1);
    chk($sformatf("%s done_count_u4", name), 32'(c4), 32'd1);
  endtask
  task automatic run16(string name, logic [1:0] o, logic [15:0] a, logic [15:0] b, logic [15:0] exp);
    int n = -1, c = 0;
    int lat = (b == 16'h0 || (!o[0] && a == 16'h8000 && b == 16'hFFFF)) ? 1 : 9;
    start16 = 1'b1;
    op16 = o;
    a16 = a;
    b16 = b;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start16 = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      if (done16) begin
        c++;
        if (n < 0) begin
          n = k - 1;
          chk($sformatf("%s result", name), 32'(result16), 32'(exp));
        end
      end
    end
    chk($sformatf("%s latency", name), 32'(n), 32'(lat));
    chk($sformatf("%s done_count", name), 32'(c), 32'd1);
  endtask
  initial begin
    vec_t tbl[10];
    logic [1:0] o;
    logic [31:0] a, b;
    logic [15:0] x, y;
    int c, e1, e2;
    tbl[0] = '{2'b01, 32'd789, 32'd7, 32'd112, 33};
    tbl[1] = '{2'b11, 32'd789, 32'd7, 32'd5, 33};
    tbl[2] = '{2'b00, 32'hFFFFE12E, 32'd456, 32'hFFFFFFEF, 33};
    tbl[3] = '{2'b10, 32'hFFFFE12E, 32'd456, 32'hFFFFFF76, 33};
    tbl[4] = '{2'b10, 32'd7890, 32'hFFFFFE38, 32'd138, 33};
    tbl[5] = '{2'b01, 32'd123, 32'd0, 32'hFFFFFFFF, 1};
    tbl[6] = '{2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1};
    tbl[7] = '{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    tbl[8] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
    tbl[9] = '{2'b01, 32'hFFFFFFFF, 32'd3, 32'h55555555, 33};
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case (i % 5)
        0: b = 32'($urandom_range(1, 15));
        1: b = (i % 10 == 1) ? 32'd0 : 32'($urandom_range(1, 300));
        2: begin a = 32'h80000000; b = (i % 10 == 2) ? 32'hFFFFFFFF : $urandom; end
        3: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      run($sformatf("rand%0d", i), o, a, b, model(32, o, a, b),
          (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 33);
    end
    run16("x16 div 8000/3", 2'b00, 16'h8000, 16'h0003, 16'hD556);
    for (int i = 0; i < 12; i++) begin
      o = 2'($urandom);
      x = 16'($urandom);
      y = (i % 3 == 0) ? 16'($urandom_range(1, 9)) : (i == 4) ? 16'h0 : 16'($urandom);
      run16($sformatf("x16 rand%0d", i), o, x, y, 16'(model(16, o, {16'h0, x}, {16'h0, y})));
    end
    c = 0;
    e1 = -1;
    e2 = -1;
    start = 1'b1;
    op = 2'b01;
    rs1 = 32'd100;
    rs2 = 32'd3;
    for (int k = 1; k <= 80 && c < 2; k++) begin
      @(negedge clk);
      if (done) begin
        c++;
        chk($sformatf("hold result%0d", c), result, 32'd33);
        if (c == 1) e1 = k - 1;
        else begin
          e2 = k - 1;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("hold done_count", 32'(c), 32'd2);
    chk("hold first_done", 32'(e1), 32'd33);
    chk("hold second_done", 32'(e2), 32'd67);
    repeat (12) @(negedge clk);
    start = 1'b1;
    op = 2'b01;
    rs1 = 32'd100;
    rs2 = 32'd7;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort busy_before", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", result, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    c = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) c++;
    end
    chk("abort no_done", 32'(c), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
